// File: rtl/axi4_rd_responder.sv
// -----------------------------------------------------------------------------
// axi4_rd_responder
//
// AXI4 read-channel responder. Each accepted AR request is answered with
// arlen+1 R beats whose data is the beat's byte address (zero-extended or
// truncated to DSIZE). FIXED bursts repeat the start address, and INCR bursts
// advance by DSIZE/8 bytes per beat, wrapping modulo 2^ASIZE. WRAP and the
// reserved encoding 11 are answered with SLVERR beats that carry zero data.
//
// Optional feature (compile-time macro):
//   AXI4_RD_RESPONDER_B2B_EN - arready is also raised while the final beat
//                              of a burst is handshaking, so the next burst
//                              can follow with no idle cycle on R.
//
// Parameters:
//   DSIZE   R data width in bits (8, 16, 32, 64 or 128)
//   IDSIZE  ID width in bits
//   ASIZE   address width in bits
//   LSIZE   burst length field width in bits
//
// Ports:
//   clock            single clock, rising edge
//   rst              synchronous, active-high reset
//   arid/araddr/
//   arlen/arburst    AR request fields, latched on the AR handshake
//   arvalid/arready  AR channel handshake
//   rid/rdata/
//   rresp/rlast      R beat fields, held stable while rvalid && !rready
//   rvalid/rready    R channel handshake
// -----------------------------------------------------------------------------
module axi4_rd_responder #(
    parameter int DSIZE  = 32,
    parameter int IDSIZE = 2,
    parameter int ASIZE  = 8,
    parameter int LSIZE  = 9
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [IDSIZE-1:0] arid,
    input  logic [ASIZE-1:0]  araddr,
    input  logic [LSIZE-1:0]  arlen,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [IDSIZE-1:0] rid,
    output logic [DSIZE-1:0]  rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

`ifdef AXI4_RD_RESPONDER_B2B_EN
    localparam logic B2B_EN = 1'b1;
`else
    localparam logic B2B_EN = 1'b0;
`endif

    localparam logic [ASIZE-1:0] ADDR_STEP   = ASIZE'(DSIZE / 8);
    localparam logic [1:0]       BURST_INCR  = 2'b01;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_arready;
    logic [IDSIZE-1:0] r_id;
    logic [ASIZE-1:0]  r_addr;
    logic [LSIZE-1:0]  r_len;
    logic [1:0]        r_burst;
    logic [LSIZE-1:0]  r_cnt;

    logic              w_load;
    logic              w_step;
    logic              w_rvalid;
    logic              w_rlast;
    logic              w_unsup;
    logic              w_beat_hs;
    logic              w_last_hs;
    logic              w_ar_hs;
    logic [DSIZE-1:0]  w_addr_ext;

    // Address presented as data: pad or cut to the R data width.
    generate
        if (DSIZE > ASIZE) begin : g_addr_ext
            assign w_addr_ext = {{(DSIZE - ASIZE){1'b0}}, r_addr};
        end else begin : g_addr_trunc
            assign w_addr_ext = r_addr[DSIZE-1:0];
        end
    endgenerate

    always_comb begin
        w_rvalid  = (r_state == ST_BURST);
        w_rlast   = w_rvalid && (r_cnt == r_len);
        w_unsup   = r_burst[1];
        w_beat_hs = w_rvalid && rready;
        w_last_hs = w_beat_hs && w_rlast;
        // r_arready covers IDLE; the final-beat term only exists with B2B.
        arready   = r_arready || (B2B_EN && w_last_hs);
        w_ar_hs   = arvalid && arready;
    end

    always_comb begin
        rvalid = w_rvalid;
        rlast  = w_rlast;
        rid    = r_id;
        rresp  = w_unsup ? RESP_SLVERR : RESP_OKAY;
        rdata  = w_unsup ? '0 : w_addr_ext;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt = ST_BURST;
                    w_load      = 1'b1;
                end
            end
            ST_BURST: begin
                if (w_last_hs) begin
                    // Without B2B, w_ar_hs is always 0 here since r_arready is 0.
                    if (w_ar_hs) begin
                        w_state_nxt = ST_BURST;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_beat_hs) begin
                    w_step = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= (w_state_nxt == ST_IDLE);
            if (w_load) begin
                r_id    <= arid;
                r_addr  <= araddr;
                r_len   <= arlen;
                r_burst <= arburst;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_burst == BURST_INCR) begin
                    r_addr <= r_addr + ADDR_STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_rd_responder.sv
// -----------------------------------------------------------------------------
// tb_axi4_rd_responder
//
// Self-checking bench for axi4_rd_responder with default parameters. Expected
// beats come from a burst-level model: beat k of a request is derived directly
// from the start address, burst type and k. Inputs are driven and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi4_rd_responder;

    localparam int DW  = 32;
    localparam int IW  = 2;
    localparam int AW  = 8;
    localparam int LW  = 9;
    localparam int BW  = 1 + IW + DW + 2 + 1;

    logic          clock = 1'b0;
    logic          rst;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [LW-1:0] arlen;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    int n_cmp = 0;
    int n_err = 0;

    axi4_rd_responder #(
        .DSIZE  (DW),
        .IDSIZE (IW),
        .ASIZE  (AW),
        .LSIZE  (LW)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {rvalid, rid, rdata, rresp, rlast} for beat k of a request.
    function automatic logic [BW-1:0] exp_beat(input logic [IW-1:0] id,
                                               input logic [AW-1:0] addr,
                                               input logic [LW-1:0] len,
                                               input logic [1:0]    burst,
                                               input int            k);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    resp;
        a    = (burst == 2'b01) ? AW'(int'(addr) + (DW / 8) * k) : addr;
        d    = (burst == 2'b10 || burst == 2'b11) ? '0 : DW'(a);
        resp = (burst == 2'b10 || burst == 2'b11) ? 2'b10 : 2'b00;
        return {1'b1, id, d, resp, (k == int'(len))};
    endfunction

    function automatic logic [BW-1:0] act_beat();
        return {rvalid, rid, rdata, rresp, rlast};
    endfunction

    // Present a request from the current falling edge and wait for acceptance.
    // Returns at the falling edge after the handshake edge.
    task automatic issue_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [LW-1:0] len, input logic [1:0] burst,
                            output bit ok);
        int n;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arburst = burst;
        arvalid = 1'b1;
        n       = 0;
        ok      = 1'b1;
        while (arready !== 1'b1) begin
            @(negedge clock);
            n++;
            if (n > 16) begin
                n_cmp++;
                n_err++;
                $display("FAIL ar_accept: arready=%b after %0d cycles, required 1", arready, n);
                arvalid = 1'b0;
                ok      = 1'b0;
                return;
            end
        end
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    // Check nbeats beats of the current burst. mode: 0 rready=1,
    // 1 rready alternating starting at 1, 2 random rready.
    task automatic run_beats(input string name, input logic [IW-1:0] id,
                             input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input logic [1:0] burst, input int nbeats,
                             input int mode, input bit check_end);
        int k;
        int c;
        logic [BW-1:0] e;
        logic [BW-1:0] a;
        k = 0;
        c = 0;
        while (k < nbeats) begin
            e = exp_beat(id, addr, len, burst, k);
            a = act_beat();
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s beat %0d cycle %0d: got %h required %h", name, k, c, a, e);
            end
            case (mode)
                0:       rready = 1'b1;
                1:       rready = ((c % 2) == 0);
                default: rready = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clock);
            if (rready) k++;
            c++;
        end
        rready = 1'b0;
        if (check_end) begin
            n_cmp++;
            if (rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL %s end_rvalid: got %b required 0", name, rvalid);
            end
        end
    endtask

    task automatic full_burst(input string name, input logic [IW-1:0] id,
                              input logic [AW-1:0] addr, input logic [LW-1:0] len,
                              input logic [1:0] burst, input int mode);
        bit ok;
        issue_ar(id, addr, len, burst, ok);
        if (ok) run_beats(name, id, addr, len, burst, int'(len) + 1, mode, 1'b1);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        arvalid = 1'b0;
        rready  = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arburst = '0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({arready, act_beat()} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got arready=%b beat=%h required all zero", arready, act_beat());
        end
        rst = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (arready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_arready: got %b required 1", arready);
        end
    endtask

    task automatic test_incr();
        full_burst("incr", 2'd2, 8'h10, 9'd3, 2'b01, 0);
    endtask

    task automatic test_fixed_backpressure();
        full_burst("fixed_bp", 2'd1, 8'h40, 9'd2, 2'b00, 1);
    endtask

    task automatic test_unsupported();
        full_burst("wrap_unsup", 2'd3, 8'h24, 9'd1, 2'b10, 0);
        full_burst("rsvd_unsup", 2'd0, 8'h88, 9'd2, 2'b11, 2);
    endtask

    task automatic test_addr_wrap();
        full_burst("addr_wrap", 2'd1, 8'hF8, 9'd3, 2'b01, 0);
    endtask

    task automatic test_max_len();
        full_burst("max_len", 2'd2, 8'h04, 9'h1FF, 2'b01, 0);
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        issue_ar(2'd3, 8'h20, 9'd7, 2'b01, ok);
        if (!ok) return;
        run_beats("mid_rst_pre", 2'd3, 8'h20, 9'd7, 2'b01, 3, 0, 1'b0);
        rready = 1'b1;
        rst    = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({arready, rvalid, rlast} !== 3'b000) begin
            n_err++;
            $display("FAIL mid_rst_abandon: got arready,rvalid,rlast=%b required 000", {arready, rvalid, rlast});
        end
        @(negedge clock);
        rst    = 1'b0;
        rready = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({arready, rvalid} !== 2'b10) begin
            n_err++;
            $display("FAIL mid_rst_release: got arready,rvalid=%b required 10", {arready, rvalid});
        end
        full_burst("mid_rst_post", 2'd1, 8'h60, 9'd2, 2'b01, 0);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [BW-1:0] e;
        arid    = 2'd1;
        araddr  = 8'h30;
        arlen   = 9'd0;
        arburst = 2'b01;
        arvalid = 1'b1;
        rready  = 1'b1;
        n       = 0;
        while (arready !== 1'b1 && n < 16) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        e = exp_beat(2'd1, 8'h30, 9'd0, 2'b01, 0);
        n_cmp++;
        if (act_beat() !== e) begin
            n_err++;
            $display("FAIL b2b_first: got %h required %h", act_beat(), e);
        end
        arid   = 2'd3;
        araddr = 8'h50;
`ifdef AXI4_RD_RESPONDER_B2B_EN
        n_cmp++;
        if (arready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_arready_last: got %b required 1", arready);
        end
        @(negedge clock);
        arvalid = 1'b0;
`else
        n_cmp++;
        if (arready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_arready_burst: got %b required 0", arready);
        end
        @(negedge clock);
        n_cmp++;
        if ({rvalid, arready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_gap: got rvalid,arready=%b required 01", {rvalid, arready});
        end
        @(negedge clock);
        arvalid = 1'b0;
`endif
        e = exp_beat(2'd3, 8'h50, 9'd0, 2'b01, 0);
        n_cmp++;
        if (act_beat() !== e) begin
            n_err++;
            $display("FAIL b2b_second: got %h required %h", act_beat(), e);
        end
        @(negedge clock);
        rready = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got rvalid=%b required 0", rvalid);
        end
    endtask

    task automatic test_random();
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [1:0]    burst;
        for (int i = 0; i < 25; i++) begin
            id    = IW'($urandom_range(0, 3));
            addr  = AW'($urandom_range(0, 255));
            len   = LW'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 3));
            full_burst("random", id, addr, len, burst, 2);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_incr();
        test_fixed_backpressure();
        test_unsupported();
        test_addr_wrap();
        test_reset_mid_burst();
        test_back_to_back();
        test_max_len();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_rd_responder.md
AXI4_RD_RESPONDER -- requirements
Module: axi4_rd_responder

Interface
REQ-001 Parameter DSIZE, default 32, the R data width in bits; legal values are 8, 16, 32, 64 and 128.
REQ-002 Parameter IDSIZE, default 2, the ID width in bits.
REQ-003 Parameter ASIZE, default 8, the address width in bits.
REQ-004 Parameter LSIZE, default 9, the burst length field width in bits.
REQ-005 clock  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 arid  input  IDSIZE  read request ID.
REQ-008 araddr  input  ASIZE  start byte address.
REQ-009 arlen  input  LSIZE  beats minus one.
REQ-010 arburst  input  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
REQ-011 arvalid / arready  input / output  1 each  AR channel handshake.
REQ-012 rid  output  IDSIZE  response ID.
REQ-013 rdata  output  DSIZE  read data.
REQ-014 rresp  output  2  response code: 00 OKAY, 10 SLVERR.
REQ-015 rlast  output  1  marks the final beat of a burst.
REQ-016 rvalid / rready  output / input  1 each  R channel handshake.

Function
REQ-017 The block SHALL act as the AXI4 read-channel responder, answering each AR request with exactly arlen+1 R beats.
REQ-018 The FSM SHALL have two states: IDLE and BURST; IDLE goes to BURST on AR handshake; BURST goes to IDLE on the handshake of the beat with rlast=1 (unless REQ-028 applies).
REQ-019 arready SHALL be 1 in IDLE and 0 in BURST, except as given in REQ-028.
REQ-020 AR handshake (arvalid&&arready) SHALL latch arid, araddr, arlen and arburst; rvalid SHALL rise on the next cycle (1-cycle AR-to-R latency).
REQ-021 rdata SHALL equal the current beat address zero-extended to DSIZE bits; if DSIZE<ASIZE it SHALL be truncated to DSIZE bits.
REQ-022 Beat address SHALL follow the burst type:
- INCR: advance by DSIZE/8 after each R handshake, wrapping modulo 2^ASIZE.
- FIXED: stay constant.
REQ-023 arburst=WRAP or 11 SHALL still produce arlen+1 beats, with rresp=10 and rdata=0 on every beat; all other bursts SHALL give rresp=00.
REQ-024 rid SHALL hold the latched arid for the whole burst.
REQ-025 rlast SHALL be 1 only when the beat counter equals the latched arlen.
REQ-026 Once rvalid=1 it SHALL stay 1, with rid, rdata, rresp and rlast held stable, until rready=1 (no beat withdrawal).
REQ-027 Beat counter width SHALL be LSIZE; arlen=2^LSIZE-1 SHALL produce 2^LSIZE beats with no overflow before rlast.

Reset
REQ-029 While rst=1 on a clock edge: FSM=IDLE, arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=00, beat counter=0.
REQ-030 arready SHALL rise on the first cycle after rst deasserts.
REQ-031 rst asserted mid-burst SHALL abandon the burst; no further beats of it SHALL be issued.

Configuration
REQ-028 With macro AXI4_RD_RESPONDER_B2B_EN defined:
- arready SHALL also be 1 during the cycle where rvalid&&rready&&rlast=1.
- An AR handshake in that cycle SHALL start the next burst with rvalid staying 1 on the following cycle (zero idle cycles).
- Without the macro, at least one cycle of rvalid=0 SHALL separate bursts, and arready SHALL be 0 throughout BURST.

Verification
REQ-032 INCR burst:
- Stimulus: DSIZE=32, araddr=0x10, arlen=3, arburst=01, arid=2, rready=1.
- Response: rdata 0x10, 0x14, 0x18, 0x1C; rlast only on 4th beat; rid=2; rresp=00.
REQ-033 FIXED burst with backpressure:
- Stimulus: araddr=0x40, arlen=2, rready toggling 1,0,1,0,1.
- Response: three beats, all rdata=0x40; signals stable while rready=0.
REQ-034 Unsupported WRAP burst:
- Stimulus: arburst=10, arlen=1.
- Response: two beats, rresp=10, rdata=0, rlast on 2nd beat.
REQ-035 Address wrap:
- Stimulus: INCR, araddr=0xF8, arlen=3.
- Response: rdata 0xF8, 0xFC, 0x00, 0x04.
REQ-036 Reset mid-burst:
- Stimulus: arlen=7; rst=1 after 3 beats.
- Response: next cycle rvalid=0; after release, arready=1 and a new burst completes normally.
REQ-037 Back-to-back bursts:
- Stimulus: arvalid held 1 for two arlen=0 requests.
- Response with AXI4_RD_RESPONDER_B2B_EN: rvalid is 1 on two consecutive cycles.
- Response without the macro: a one-cycle gap appears between the bursts.
